decode_pipe_unit: RTL and testbench
===================================

Name: decode_pipe_unit

Overview:
- Parametrised decode stage that owns the GPR file, generates RISC-V immediates, and registers decoded operands into a D/E pipeline register with a valid/ready handshake.
- Sits between the fetch/decode boundary and the execute stage.
- Adds over the previous decode block: configurable XLEN and register count, stall/flush control, and refresh of stalled operands on writeback. Optionally adds same-cycle W-to-D bypass.

Parameters:
- XLEN, 32, datapath width; immediates sign-extend from inst[31] to XLEN.
- NREG, 32, number of GPRs; register 0 is hardwired to zero. Address width is AW = $clog2(NREG), fixed at 5 for the RV encoding. NREG < 32 ignores the upper address bits for storage, but they still participate in compares.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- D_valid  in  1  instruction on D_inst is valid.
- D_ready  out  1  stage can accept: !E_valid || E_ready.
- D_inst  in  25  instruction bits [31:7].
- D_imm_control  in  3  immediate type: 0=I, 1=S, 2=B, 3=J, 4=U; 5-7 produce zero.
- W_gpr_wen  in  1  writeback enable.
- W_rd_addr  in  5  writeback destination.
- W_rd  in  XLEN  writeback data.
- flush  in  1  kill the D/E register contents.
- E_ready  in  1  execute stage accepts E outputs this cycle.
- E_valid  out  1  E outputs hold a valid instruction.
- E_rs1, E_rs2  out  XLEN each  registered operand values.
- E_imm_ext  out  XLEN  registered immediate.
- E_rd_addr, E_rs1_addr, E_rs2_addr  out  5 each  registered addresses for the hazard unit.

Behaviour:
- Reset (async): all GPRs = 0, E_valid = 0, all E_* data/address outputs = 0.
- GPR write: on posedge when W_gpr_wen && W_rd_addr != 0, writes W_rd. Writes to x0 are discarded; reads of x0 return 0.
- GPR read ports: combinational, addressed by inst[19:15] and inst[24:20].
- Immediates:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - U = {inst[31:12], 12'b0}
  - All are sign-extended to XLEN.
- Load: on posedge when D_valid && D_ready && !flush, E_* <= decoded values and E_valid <= 1.
- Drain: on posedge when E_valid && E_ready && !(D_valid && D_ready), E_valid <= 0. Data outputs hold their values.
- Stall: when E_valid && !E_ready, E_* hold their values and D_ready = 0. Upstream must hold D_inst/D_valid stable.
- Stall refresh: while stalled, if W_gpr_wen && W_rd_addr != 0 && W_rd_addr == E_rs1_addr, E_rs1 <= W_rd. The same rule applies independently to E_rs2. This means a held instruction never carries a stale operand.
- Flush: on posedge with flush = 1, E_valid <= 0. Flush has priority over load and stall, and any D_valid instruction that cycle is dropped. D_ready is unaffected by flush.
- Latency: one cycle from D acceptance to E_valid.
- Throughput: one instruction per cycle when E_ready is held at 1.
- Simultaneous W write and D read of the same register: returns the old value unless DECODE_WB_BYPASS_EN is defined.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: the read path is write-first. If W_gpr_wen && W_rd_addr != 0 && W_rd_addr == read addr, the operand = W_rd in the same cycle.
- Undefined: the read path returns array contents only, and the hazard unit must stall one cycle for W-to-D dependences.
- Stall refresh is present in both builds.

Test Plan:
- Reset asserted mid-stream with E_valid = 1 -> E_valid = 0 and all E_* = 0 immediately (async); a subsequent read of x5 returns 0.
- Write x5 = 0x1234 at cycle N, then decode "addi x6, x5, -1" (inst[31:20] = 0xFFF, ctrl = 0) at N+1 -> next cycle E_rs1 = 0x1234, E_imm_ext = 0xFFFFFFFF, E_rd_addr = 6, E_valid = 1.
- Same cycle W writes x7 = 0xA5A5 and D reads rs2 = x7 (old value 0x11) -> E_rs2 = 0xA5A5 with the macro defined, 0x11 without it.
- E_valid = 1 with E_ready = 0 for 3 cycles, E_rs1_addr = 3, W writes x3 = 0xBEEF in the 2nd cycle -> D_ready = 0 throughout, E_rs1 = 0xBEEF afterwards, other fields unchanged; on E_ready = 1 the next instruction loads.
- flush = 1 together with D_valid = 1 -> E_valid = 0 next cycle. Separately, write to x0 of 0xFFFF -> subsequent reads of x0 return 0.
- Immediate sweep with inst[31] = 1 for B (bits giving -4096), J (-1048576) and U (0x80000000), and XLEN = 64 -> E_imm_ext = 0xFFFFFFFFFFFFF000, 0xFFFFFFFFFFF00000, 0xFFFFFFFF80000000 respectively.

Source files
------------

// File: rtl/decode_pipe_unit.sv
// Decode stage: GPR file, RISC-V immediate generation and a valid/ready D/E register.
// Define DECODE_WB_BYPASS_EN for a write-first (same-cycle W-to-D bypass) read path.
module decode_pipe_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            D_valid,
  output logic            D_ready,
  input  logic [24:0]     D_inst,
  input  logic [2:0]      D_imm_control,
  input  logic            W_gpr_wen,
  input  logic [4:0]      W_rd_addr,
  input  logic [XLEN-1:0] W_rd,
  input  logic            flush,
  input  logic            E_ready,
  output logic            E_valid,
  output logic [XLEN-1:0] E_rs1,
  output logic [XLEN-1:0] E_rs2,
  output logic [XLEN-1:0] E_imm_ext,
  output logic [4:0]      E_rd_addr,
  output logic [4:0]      E_rs1_addr,
  output logic [4:0]      E_rs2_addr
);

  localparam int AW = 5;
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_e;

  // Keep the RV bit numbering so the immediate formulas read like the ISA manual.
  logic [31:7] inst;
  assign inst = D_inst;

  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign rd_addr  = inst[11:7];

  logic wb_write;
  assign wb_write = W_gpr_wen && (W_rd_addr != '0);

  // ---------------- GPR file ----------------
  logic [XLEN-1:0] gpr [NREG];

  // NOTE: the register file is cleared on reset because the block must come up with all GPRs at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wb_write) begin
      gpr[W_rd_addr[SW-1:0]] <= W_rd;
    end
  end

  function automatic logic [XLEN-1:0] read_gpr(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = (addr == '0) ? '0 : gpr[addr[SW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_write && (W_rd_addr == addr)) val = W_rd;
`endif
    return val;
  endfunction

  logic [XLEN-1:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = read_gpr(rs1_addr);
    rs2_val = read_gpr(rs2_addr);
  end

  // ---------------- Immediate generation ----------------
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_ext;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    imm32 = '0;
    case (imm_sel_e'(D_imm_control))
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    // Size cast of a signed value sign-extends to XLEN.
    imm_ext = XLEN'(imm32);
  end

  // ---------------- D/E pipeline register ----------------
  logic load, stall, rs1_refresh, rs2_refresh;
  assign D_ready     = !E_valid || E_ready;
  assign load        = D_valid && D_ready && !flush;
  assign stall       = E_valid && !E_ready;
  assign rs1_refresh = stall && wb_write && (W_rd_addr == E_rs1_addr);
  assign rs2_refresh = stall && wb_write && (W_rd_addr == E_rs2_addr);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_valid    <= 1'b0;
      E_rs1      <= '0;
      E_rs2      <= '0;
      E_imm_ext  <= '0;
      E_rd_addr  <= '0;
      E_rs1_addr <= '0;
      E_rs2_addr <= '0;
    end else if (flush) begin
      E_valid <= 1'b0;
    end else if (load) begin
      E_valid    <= 1'b1;
      E_rs1      <= rs1_val;
      E_rs2      <= rs2_val;
      E_imm_ext  <= imm_ext;
      E_rd_addr  <= rd_addr;
      E_rs1_addr <= rs1_addr;
      E_rs2_addr <= rs2_addr;
    end else begin
      if (E_valid && E_ready) E_valid <= 1'b0;
      // A held instruction picks up writebacks so it never carries a stale operand.
      if (rs1_refresh) E_rs1 <= W_rd;
      if (rs2_refresh) E_rs2 <= W_rd;
    end
  end

endmodule

// File: tb/tb_decode_pipe_unit.sv
// Self-checking bench for decode_pipe_unit (XLEN = 64): reference model + scoreboard queue,
// a table of immediate vectors, and hand-written stall/flush/bypass/reset sequences.
module tb_decode_pipe_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            D_valid;
  logic            D_ready;
  logic [24:0]     D_inst;
  logic [2:0]      D_imm_control;
  logic            W_gpr_wen;
  logic [4:0]      W_rd_addr;
  logic [XLEN-1:0] W_rd;
  logic            flush;
  logic            E_ready;
  logic            E_valid;
  logic [XLEN-1:0] E_rs1, E_rs2, E_imm_ext;
  logic [4:0]      E_rd_addr, E_rs1_addr, E_rs2_addr;

  decode_pipe_unit #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .D_valid(D_valid), .D_ready(D_ready), .D_inst(D_inst), .D_imm_control(D_imm_control),
    .W_gpr_wen(W_gpr_wen), .W_rd_addr(W_rd_addr), .W_rd(W_rd),
    .flush(flush), .E_ready(E_ready), .E_valid(E_valid),
    .E_rs1(E_rs1), .E_rs2(E_rs2), .E_imm_ext(E_imm_ext),
    .E_rd_addr(E_rd_addr), .E_rs1_addr(E_rs1_addr), .E_rs2_addr(E_rs2_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
  } exp_t;

  typedef struct {
    logic [24:0]     inst;
    logic [2:0]      ctrl;
    logic [XLEN-1:0] imm;
  } imm_vec_t;

  int check_count = 0;
  int err_count   = 0;

  exp_t            sb[$];
  exp_t            m_cur;
  logic            m_valid;
  logic [XLEN-1:0] m_gpr [32];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    check_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] imm_model(input logic [24:0] di, input logic [2:0] ctrl);
    logic [31:0] w;
    logic [31:0] x;
    w = {di, 7'b0};
    case (ctrl)
      3'd0:    x = {{20{w[31]}}, w[31:20]};
      3'd1:    x = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    x = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    x = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'd4:    x = {w[31:12], 12'b0};
      default: x = 32'b0;
    endcase
    return sext32(x);
  endfunction

  function automatic logic [XLEN-1:0] read_model(input logic [4:0] ra, input logic wen,
                                                 input logic [4:0] wa, input logic [XLEN-1:0] wd);
    if (ra == 5'd0) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (wen && wa != 5'd0 && wa == ra) return wd;
`endif
    return m_gpr[ra];
  endfunction

  // One clock cycle: drive at negedge, predict, advance, compare at the next negedge.
  task automatic step(input logic v, input logic [24:0] di, input logic [2:0] ctrl,
                      input logic wen, input logic [4:0] wa, input logic [XLEN-1:0] wd,
                      input logic fl, input logic er);
    exp_t e;
    logic acc, exp_rdy;
    D_valid = v; D_inst = di; D_imm_control = ctrl;
    W_gpr_wen = wen; W_rd_addr = wa; W_rd = wd; flush = fl; E_ready = er;
    #1;
    exp_rdy = !m_valid || er;
    check("D_ready", XLEN'(D_ready), XLEN'(exp_rdy));
    acc = v && exp_rdy && !fl;
    if (acc) begin
      e.ra1 = di[12:8];
      e.ra2 = di[17:13];
      e.rd  = di[4:0];
      e.rs1 = read_model(e.ra1, wen, wa, wd);
      e.rs2 = read_model(e.ra2, wen, wa, wd);
      e.imm = imm_model(di, ctrl);
      sb.push_back(e);
    end
    @(posedge clk);
    if (!fl && !acc && m_valid && !er && wen && wa != 5'd0) begin
      if (wa == m_cur.ra1) m_cur.rs1 = wd;
      if (wa == m_cur.ra2) m_cur.rs2 = wd;
    end
    if (fl)                  m_valid = 1'b0;
    else if (acc)            m_valid = 1'b1;
    else if (m_valid && er)  m_valid = 1'b0;
    if (wen && wa != 5'd0) m_gpr[wa] = wd;
    @(negedge clk);
    check("E_valid", XLEN'(E_valid), XLEN'(m_valid));
    if (acc) begin
      if (sb.size() == 0) check("scoreboard_empty", 1, 0);
      else m_cur = sb.pop_front();
    end
    if (m_valid) begin
      check("E_rs1", E_rs1, m_cur.rs1);
      check("E_rs2", E_rs2, m_cur.rs2);
      check("E_imm_ext", E_imm_ext, m_cur.imm);
      check("E_rd_addr", XLEN'(E_rd_addr), XLEN'(m_cur.rd));
      check("E_rs1_addr", XLEN'(E_rs1_addr), XLEN'(m_cur.ra1));
      check("E_rs2_addr", XLEN'(E_rs2_addr), XLEN'(m_cur.ra2));
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
  endtask

  task automatic check_e_zero(input string tag);
    check({tag, "_E_valid"}, XLEN'(E_valid), 0);
    check({tag, "_E_rs1"}, E_rs1, 0);
    check({tag, "_E_rs2"}, E_rs2, 0);
    check({tag, "_E_imm"}, E_imm_ext, 0);
    check({tag, "_E_addrs"}, XLEN'({E_rd_addr, E_rs1_addr, E_rs2_addr}), 0);
  endtask

  imm_vec_t imm_tab [9];
  logic [XLEN-1:0] rs2_exp;
  logic [XLEN-1:0] held_imm;
  logic [4:0]      held_rd;

  initial begin
    imm_tab[0] = '{25'h1000000, 3'd2, 64'hFFFFFFFFFFFFF000};  // B, -4096
    imm_tab[1] = '{25'h1000000, 3'd3, 64'hFFFFFFFFFFF00000};  // J, -1048576
    imm_tab[2] = '{25'h1000000, 3'd4, 64'hFFFFFFFF80000000};  // U, 0x80000000
    imm_tab[3] = '{25'h0FFE000, 3'd0, 64'h00000000000007FF};  // I, +2047
    imm_tab[4] = '{25'h0040005, 3'd1, 64'h0000000000000025};  // S
    imm_tab[5] = '{25'h1FFFFFF, 3'd5, 64'h0000000000000000};  // reserved
    imm_tab[6] = '{25'h1FFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF};  // I, -1
    imm_tab[7] = '{25'h0000001, 3'd2, 64'h0000000000000800};  // B, inst[7] -> bit 11
    imm_tab[8] = '{25'h0003FE0, 3'd3, 64'h00000000000FF800};  // J, inst[20] + inst[19:12]

    reset = 1'b1; D_valid = 0; D_inst = '0; D_imm_control = '0;
    W_gpr_wen = 0; W_rd_addr = '0; W_rd = '0; flush = 0; E_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_e_zero("reset");
    reset = 1'b0;

    // Immediate sweep.
    for (int i = 0; i < 9; i++) begin
      step(1, imm_tab[i].inst, imm_tab[i].ctrl, 0, 0, 0, 0, 1);
      check($sformatf("imm_tab[%0d]", i), E_imm_ext, imm_tab[i].imm);
    end
    step(0, '0, 0, 0, 0, 0, 0, 1);  // drain

    // Write x5, then addi x6, x5, -1.
    step(0, '0, 0, 1, 5'd5, 64'h1234, 0, 1);
    step(1, 25'h1FFE506, 3'd0, 0, 0, 0, 0, 1);
    check("addi_rs1", E_rs1, 64'h1234);
    check("addi_imm", E_imm_ext, 64'hFFFFFFFFFFFFFFFF);
    check("addi_rd", XLEN'(E_rd_addr), 6);
    check("addi_valid", XLEN'(E_valid), 1);

    // Same-cycle W write and D read of x7.
    step(0, '0, 0, 1, 5'd7, 64'h11, 0, 1);
`ifdef DECODE_WB_BYPASS_EN
    rs2_exp = 64'hA5A5;
`else
    rs2_exp = 64'h11;
`endif
    step(1, 25'd7 << 13, 3'd0, 1, 5'd7, 64'hA5A5, 0, 1);
    check("wd_rs2", E_rs2, rs2_exp);

    // Stall with refresh of rs1 = x3.
    step(1, (25'd3 << 8) | (25'd9 << 13) | 25'd4, 3'd1, 0, 0, 0, 0, 1);
    held_imm = E_imm_ext;
    held_rd  = E_rd_addr;
    step(1, 25'd5 << 8, 3'd0, 0, 0, 0, 0, 0);
    step(1, 25'd5 << 8, 3'd0, 1, 5'd3, 64'hBEEF, 0, 0);
    step(1, 25'd5 << 8, 3'd0, 0, 0, 0, 0, 0);
    check("stall_rs1", E_rs1, 64'hBEEF);
    check("stall_imm", E_imm_ext, held_imm);
    check("stall_rd", XLEN'(E_rd_addr), XLEN'(held_rd));
    step(1, 25'd5 << 8, 3'd0, 0, 0, 0, 0, 1);
    check("after_stall_rs1_addr", XLEN'(E_rs1_addr), 5);
    check("after_stall_rs1", E_rs1, 64'h1234);

    // Flush drops a valid instruction.
    step(1, 25'd6 << 8, 3'd0, 0, 0, 0, 1, 1);
    check("flush_valid", XLEN'(E_valid), 0);

    // Write to x0 is discarded.
    step(0, '0, 0, 1, 5'd0, 64'hFFFF, 0, 1);
    step(1, 25'd0, 3'd0, 0, 0, 0, 0, 1);
    check("x0_rs1", E_rs1, 0);
    check("x0_rs2", E_rs2, 0);

    // Reset asserted mid-stream while E_valid is high.
    step(1, 25'd5 << 8, 3'd0, 0, 0, 0, 0, 1);
    check("pre_reset_valid", XLEN'(E_valid), 1);
    #2 reset = 1'b1;
    #1;
    check_e_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1, 25'd5 << 8, 3'd0, 0, 0, 0, 0, 1);
    check("post_reset_x5", E_rs1, 0);
    step(0, '0, 0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
    $finish;
  end

endmodule
